// File: rtl/bus_pkg.sv
// Shared definitions for the native valid/ready memory bus: widths, arbiter states,
// and the request payload carried from a master to the slave.
package bus_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } bus_req_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first requester after the last winner, wrapping modulo N.
module rr_pick #(
   parameter  int unsigned N     = 4,
   localparam int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic [IDX_W-1:0] gnt,
   output logic             any_req
);

   logic [IDX_W-1:0] idx;

   // Walk the search order backwards so the closest requester after last is written last.
   always_comb begin
      gnt     = '0;
      any_req = 1'b0;
      idx     = '0;
      for (int unsigned k = N; k > 0; k--) begin
         idx = IDX_W'((32'(last) + k) % N);
         if (req[idx]) begin
            gnt     = idx;
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_rr_arbiter.sv
// N-master to 1-slave round-robin arbiter, one transaction per grant, with a watchdog
// that completes a stalled transfer with an error response.
module bus_rr_arbiter
   import bus_pkg::*;
#(
   parameter  int unsigned       N_MASTERS = 4,
   parameter  int unsigned       TIMEOUT   = 255,
   parameter  logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEFAULT,
   localparam int unsigned       IDX_W     = $clog2(N_MASTERS)
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [N_MASTERS-1:0]          m_valid,
   output logic [N_MASTERS-1:0]          m_ready,
   input  logic [ADDR_W*N_MASTERS-1:0]   m_addr,
   input  logic [DATA_W*N_MASTERS-1:0]   m_wdata,
   input  logic [STRB_W*N_MASTERS-1:0]   m_wstrb,
   output logic [DATA_W-1:0]             m_rdata,
   output logic                          s_valid,
   input  logic                          s_ready,
   output logic [ADDR_W-1:0]             s_addr,
   output logic [DATA_W-1:0]             s_wdata,
   output logic [STRB_W-1:0]             s_wstrb,
   input  logic [DATA_W-1:0]             s_rdata,
   output logic                          bus_err,
   output logic [IDX_W-1:0]              err_master
);

   localparam int unsigned       WDOG_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

   state_e            state, state_d;
   logic [IDX_W-1:0]  grant, grant_d;
   logic [IDX_W-1:0]  last, last_d;
   logic [WDOG_W-1:0] wdog, wdog_d;
   logic [IDX_W-1:0]  err_master_d;
   logic [IDX_W-1:0]  pick;
   logic              any_req;
   logic              wdog_expire;
   bus_req_t          reqs [N_MASTERS];
   bus_req_t          sel;

   for (genvar g = 0; g < N_MASTERS; g++) begin : g_req
      assign reqs[g].addr  = m_addr [g*ADDR_W +: ADDR_W];
      assign reqs[g].wdata = m_wdata[g*DATA_W +: DATA_W];
      assign reqs[g].wstrb = m_wstrb[g*STRB_W +: STRB_W];
   end

   assign sel         = reqs[grant];
   assign wdog_expire = (TIMEOUT != 0) && (wdog == WDOG_LAST);

   rr_pick #(.N(N_MASTERS)) u_pick (
      .req     (m_valid),
      .last    (last),
      .gnt     (pick),
      .any_req (any_req)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         grant      <= '0;
         last       <= IDX_W'(N_MASTERS - 1);
         wdog       <= '0;
         err_master <= '0;
      end else begin
         state      <= state_d;
         grant      <= grant_d;
         last       <= last_d;
         wdog       <= wdog_d;
         err_master <= err_master_d;
      end
   end

   // Slave-side request and master completion are driven only while BUSY, from the registered grant.
   always_comb begin
      state_d      = state;
      grant_d      = grant;
      last_d       = last;
      wdog_d       = wdog;
      err_master_d = err_master;
      s_valid      = 1'b0;
      s_addr       = '0;
      s_wdata      = '0;
      s_wstrb      = '0;
      m_ready      = '0;
      m_rdata      = '0;
      bus_err      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (any_req) begin
               grant_d = pick;
               wdog_d  = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            s_valid = 1'b1;
            s_addr  = sel.addr;
            s_wdata = sel.wdata;
            s_wstrb = sel.wstrb;
            if (s_ready) begin
               m_ready[grant] = 1'b1;
               m_rdata        = s_rdata;
               last_d         = grant;
               state_d        = ST_RELEASE;
            end else if (!m_valid[grant]) begin
               state_d = ST_IDLE;
            end else if (wdog_expire) begin
               m_ready[grant] = 1'b1;
               m_rdata        = ERR_RDATA;
               bus_err        = 1'b1;
               err_master_d   = grant;
               last_d         = grant;
               state_d        = ST_RELEASE;
            end else if (TIMEOUT != 0) begin
               wdog_d = wdog + WDOG_W'(1);
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      // A transaction caught by reset is abandoned silently.
      if (!resetn) begin
         s_valid = 1'b0;
         s_addr  = '0;
         s_wdata = '0;
         s_wstrb = '0;
         m_ready = '0;
         m_rdata = '0;
         bus_err = 1'b0;
      end
   end

endmodule
